imm_pipe: RTL and testbench
===========================

# imm_pipe

Pipelined, parametrised immediate-generation stage sitting between the decode and execute stages of the FlowLine CPU. It accepts a full 32-bit instruction plus a format select, and produces a sign- or zero-extended immediate of width XLEN one cycle later. It carries a sideband tag (PC or ROB index) alongside the immediate. A two-entry skid buffer with valid/ready handshakes on both sides, plus a synchronous flush, lets it absorb execute-stage stalls without combinational ready paths.

## Interface
- XLEN, 32: immediate width; legal values are 32 and 64.
- TAG_W, 32: width of the sideband tag passed through unchanged.

- cpu_clk  input  1  clock; all state updates on the rising edge.
- cpu_rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept; driven from a register only.
- in_instr  input  32  raw instruction word.
- in_op  input  3  format select: 0 I, 1 B, 2 J, 3 S, 4 U, 5 Z (CSR uimm), 6–7 reserved.
- in_tag  input  TAG_W  sideband.
- out_valid  output  1  entry presented downstream.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  generated immediate.
- out_tag  output  TAG_W  tag of the presented entry.
- out_illegal  output  1  the presented entry used a reserved or disabled op.

## Operation
- Format extraction uses instruction bit positions; the sign bit is always instr[31], replicated to XLEN.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended when XLEN=64.
  - Z: zero-extended instr[19:15].
  - Reserved: imm=0, illegal=1.
- Storage is a main register (M), which drives the outputs, and a skid register (K). Occupancy states are EMPTY (M and K invalid), ONE (M valid only) and TWO (M and K valid).
- Accept condition: in_valid & in_ready. Pop condition: out_valid & out_ready.
- EMPTY + accept → ONE.
- ONE + accept without pop → TWO; the new entry goes to K.
- ONE + accept with pop → ONE; the new entry replaces M.
- ONE + pop without accept → EMPTY.
- TWO + pop → ONE; K moves to M. No accept is possible in TWO.
- in_ready = ~K.valid, registered. Order is preserved; no entry is duplicated or lost.
- The immediate is computed combinationally on the input side and stored, so out_imm is a pure register output.
- flush: the next state is EMPTY regardless of accept or pop in the same cycle, and the in_valid entry in that cycle is dropped.
- cpu_rst has the same effect as flush and has priority over it.

## Timing
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_illegal=0.
- Latency is 1 cycle: an entry accepted at edge N is visible at out_* after edge N.
- Throughput is 1 entry/cycle while out_ready=1.
- When out_ready drops, one further entry is absorbed in K, and in_ready falls after the next edge.
- Data outputs are held stable while out_valid=1 and out_ready=0.
- in_ready does not depend combinationally on out_ready.
- Mid-operation reset or flush: outputs return to their reset values at the next edge.

## Configuration
- IMM_PIPE_ZIMM_EN defined: op 5 produces the zero-extended CSR uimm with illegal=0.
- IMM_PIPE_ZIMM_EN undefined: op 5 is treated as reserved, giving imm=0 and illegal=1.

## Structure
- Package imm_pkg holds:
  - Op localparams IMM_I, IMM_B, IMM_J, IMM_S, IMM_U, IMM_Z.
  - A typedef for the buffered entry struct {imm, tag, illegal}.
- Sub-module imm_decode is purely combinational: (instr, op) → (imm, illegal), parametrised by XLEN.
- imm_pipe instantiates imm_decode once and owns the M/K registers and handshake logic.

## Test plan
- I-type stream: instr 0xFFF00093 op 0, followed by instr 0x123450B7 op 4, with out_ready=1.
  - Out: imm 0xFFFFFFFF, then 0x12345000, in consecutive cycles.
- B and S with XLEN=64: instr 0xFE000EE3 op 1, then 0xFE112C23 op 3.
  - Out: imm 0xFFFFFFFFFFFFFFFC, then 0xFFFFFFFFFFFFFFF8.
- Backpressure: hold out_ready=0 while sending tags 1, 2 and 3.
  - in_ready falls after tag 2 is accepted, and tag 3 is held off.
  - On releasing out_ready, tags 1, 2, 3 emerge in order with no duplication.
- Flush in state TWO, together with in_valid=1: the next cycle has out_valid=0 and in_ready=1, and no entry emerges afterwards.
- Z op: instr with [19:15]=5'b11111, op 5.
  - With IMM_PIPE_ZIMM_EN: imm 0x1F, illegal=0.
  - Without IMM_PIPE_ZIMM_EN: imm 0, illegal=1.
  - Op 7 in either configuration: imm 0, illegal=1.
- Random stall/flush soak against a scoreboard model: the output sequence equals the input sequence minus flushed entries.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg: shared op codes, occupancy states and the buffered entry type for imm_pipe.
// Entry fields are sized to the widest supported configuration (XLEN 64, tag up to 64 bits);
// narrower instances zero-pad on write and slice on read.
package imm_pkg;
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_B = 3'd1;
    localparam logic [2:0] IMM_J = 3'd2;
    localparam logic [2:0] IMM_S = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_Z = 3'd5;
    localparam int IMM_W_MAX = 64;
    localparam int TAG_W_MAX = 64;
    typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_t;
    typedef struct packed {
        logic [IMM_W_MAX-1:0] imm;
        logic [TAG_W_MAX-1:0] tag;
        logic                 illegal;
    } entry_t;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate extraction from a 32-bit instruction.
// Ports: i_instr (instruction word), i_op (format select), o_imm (XLEN-wide immediate),
// o_illegal (reserved or disabled op). Macro IMM_PIPE_ZIMM_EN enables the CSR uimm (Z) format.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [2:0]      i_op,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);
    logic        w_s;
    logic        w_zen;
    logic [63:0] w_full;
    logic        w_unused;
`ifdef IMM_PIPE_ZIMM_EN
    assign w_zen = 1'b1;
`else
    assign w_zen = 1'b0;
`endif
    assign w_s = i_instr[31];
    // Built at 64 bits with full sign fill, then truncated to XLEN.
    always_comb begin
        w_full    = i_op == IMM_I ? {{52{w_s}}, i_instr[31:20]} :
                    i_op == IMM_S ? {{52{w_s}}, i_instr[31:25], i_instr[11:7]} :
                    i_op == IMM_B ? {{52{w_s}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0} :
                    i_op == IMM_J ? {{44{w_s}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0} :
                    i_op == IMM_U ? {{32{w_s}}, i_instr[31:12], 12'b0} :
                    (i_op == IMM_Z && w_zen) ? {59'b0, i_instr[19:15]} : 64'b0;
        o_illegal = i_op > IMM_Z || (i_op == IMM_Z && !w_zen);
    end
    assign o_imm    = w_full[XLEN-1:0];
    // Opcode bits and the truncated high bits carry no immediate information.
    assign w_unused = ^{i_instr[6:0], w_full};
endmodule

// File: rtl/imm_pipe.sv
// imm_pipe: registered immediate-generation stage with a two-entry skid buffer.
// Ports: cpu_clk/cpu_rst (sync active-high), flush (sync discard), in_valid/in_ready/in_instr/
// in_op/in_tag (upstream), out_valid/out_ready/out_imm/out_tag/out_illegal (downstream).
// Macro IMM_PIPE_ZIMM_EN (in imm_decode) enables the CSR uimm format on op 5.
module imm_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);
    occ_t            r_state;
    occ_t            w_next;
    entry_t          r_m;
    entry_t          r_k;
    entry_t          w_new;
    logic            r_in_ready;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic            w_accept;
    logic            w_pop;
    logic            w_load_m;
    logic            w_load_k;
    logic            w_shift;
    logic            w_unused;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .i_instr   (in_instr),
        .i_op      (in_op),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    assign w_new    = '{imm: IMM_W_MAX'(w_imm), tag: TAG_W_MAX'(in_tag), illegal: w_illegal};
    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = out_valid & out_ready;
    // New entry lands in M when M is free or being drained this cycle, otherwise in K.
    assign w_load_m = w_accept & (r_state == OCC_EMPTY | w_pop);
    assign w_load_k = w_accept & r_state == OCC_ONE & ~w_pop;
    assign w_shift  = w_pop & r_state == OCC_TWO;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst || flush) begin
            r_state    <= OCC_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= w_next != OCC_TWO;
        end
    end

    always_comb begin
        w_next = OCC_EMPTY;
        case (r_state)
            OCC_EMPTY: w_next = w_accept ? OCC_ONE : OCC_EMPTY;
            OCC_ONE:   w_next = (w_accept && !w_pop) ? OCC_TWO : (!w_accept && w_pop) ? OCC_EMPTY : OCC_ONE;
            OCC_TWO:   w_next = w_pop ? OCC_ONE : OCC_TWO;
            default:   w_next = OCC_EMPTY;
        endcase
    end

    always_comb begin
        out_valid   = r_state != OCC_EMPTY;
        in_ready    = r_in_ready;
        out_imm     = r_m.imm[XLEN-1:0];
        out_tag     = r_m.tag[TAG_W-1:0];
        out_illegal = r_m.illegal;
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst || flush) begin
            r_m <= '0;
            r_k <= '0;
        end else begin
            if (w_shift)
                r_m <= r_k;
            else if (w_load_m)
                r_m <= w_new;
            if (w_load_k)
                r_k <= w_new;
        end
    end

    // Padding bits of the stored entry beyond XLEN/TAG_W are never presented.
    assign w_unused = ^r_m;
endmodule

// File: tb/tb_imm_pipe.sv
// tb_imm_pipe: directed and random checks of imm_pipe at XLEN 32 and 64 against a queue model.
module tb_imm_pipe;
    import imm_pkg::*;
`ifdef IMM_PIPE_ZIMM_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif
    logic        cpu_clk = 0;
    logic        cpu_rst = 1;
    logic        flush = 0;
    logic        in_valid = 0;
    logic        out_ready = 0;
    logic [31:0] in_instr = 0;
    logic [2:0]  in_op = 0;
    logic [31:0] in_tag = 0;
    logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;

    always #5 cpu_clk = ~cpu_clk;

    imm_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_op(in_op), .in_tag(in_tag),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32)
    );
    imm_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_op(in_op), .in_tag(in_tag),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64)
    );

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  op;
        logic [31:0] tag;
    } ent_t;

    int          n_chk = 0;
    int          n_err = 0;
    ent_t        q[$];
    logic [31:0] popped[$];
    bit          cleared = 1;

    // Immediate from the format rules using arithmetic shifts on the sign-extended word.
    function automatic logic [63:0] ref_imm(logic [31:0] ins, logic [2:0] op, int xlen);
        longint sx = longint'(signed'(ins));
        longint r;
        case (op)
            3'd0:    r = sx >>> 20;
            3'd3:    r = ((sx >>> 25) <<< 5) | longint'(ins[11:7]);
            3'd1:    r = ((sx >>> 31) <<< 12) | (longint'(ins[7]) << 11) | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            3'd2:    r = ((sx >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            3'd4:    r = sx & ~64'hFFF;
            3'd5:    r = ZEN ? longint'(ins[19:15]) : 0;
            default: r = 0;
        endcase
        return xlen == 32 ? (r & 64'hFFFF_FFFF) : r;
    endfunction

    function automatic logic ref_ill(logic [2:0] op);
        return op > 3'd5 || (op == 3'd5 && !ZEN);
    endfunction

    task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("in_ready32", rdy32, q.size() < 2);
        chk("in_ready64", rdy64, q.size() < 2);
        chk("out_valid32", vld32, q.size() > 0);
        chk("out_valid64", vld64, q.size() > 0);
        if (q.size() > 0) begin
            chk("imm32", imm32, ref_imm(q[0].ins, q[0].op, 32));
            chk("imm64", imm64, ref_imm(q[0].ins, q[0].op, 64));
            chk("tag32", tag32, q[0].tag);
            chk("tag64", tag64, q[0].tag);
            chk("ill32", ill32, ref_ill(q[0].op));
            chk("ill64", ill64, ref_ill(q[0].op));
        end else if (cleared) begin
            chk("clr_imm32", imm32, 0);
            chk("clr_imm64", imm64, 0);
            chk("clr_tag32", tag32, 0);
            chk("clr_ill32", ill32, 0);
        end
    endtask

    task automatic step(bit v, logic [31:0] ins, logic [2:0] op, logic [31:0] tag, bit ordy, bit fl, bit rs);
        bit acc, pp;
        check_state();
        in_valid  = v;
        in_instr  = ins;
        in_op     = op;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        cpu_rst   = rs;
        if (vld32 && ordy && !fl && !rs) popped.push_back(tag32);
        acc = v && q.size() < 2;
        pp  = q.size() > 0 && ordy;
        if (rs || fl) begin
            q.delete();
            cleared = 1;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back('{ins, op, tag});
                cleared = 0;
            end
        end
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge cpu_clk);
        #1;
        cpu_rst = 0;
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 32'hFFF00093, 3'd0, 32'h10, 1, 0, 0);
        chk("i_imm", imm32, 32'hFFFFFFFF);
        step(1, 32'h123450B7, 3'd4, 32'h11, 1, 0, 0);
        chk("u_imm", imm32, 32'h12345000);
        step(1, 32'hFE000EE3, 3'd1, 32'h12, 1, 0, 0);
        chk("b_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
        step(1, 32'hFE112C23, 3'd3, 32'h13, 1, 0, 0);
        chk("s_imm64", imm64, 64'hFFFFFFFFFFFFFFF8);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        popped.delete();
        step(1, $urandom, 3'd0, 32'd1, 0, 0, 0);
        chk("bp_ready_1", rdy32, 1);
        step(1, $urandom, 3'd2, 32'd2, 0, 0, 0);
        chk("bp_ready_2", rdy32, 0);
        step(1, 32'h00300093, 3'd0, 32'd3, 0, 0, 0);
        chk("bp_hold_tag", tag32, 32'd1);
        step(1, 32'h00300093, 3'd0, 32'd3, 1, 0, 0);
        step(1, 32'h00300093, 3'd0, 32'd3, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("bp_count", popped.size(), 3);
        for (int i = 0; i < popped.size() && i < 3; i++) chk("bp_order", popped[i], i + 1);
        step(1, $urandom, 3'd1, 32'd21, 0, 0, 0);
        step(1, $urandom, 3'd2, 32'd22, 0, 0, 0);
        step(1, $urandom, 3'd4, 32'd23, 0, 1, 0);
        chk("fl_valid", vld32, 0);
        chk("fl_ready", rdy32, 1);
        popped.delete();
        repeat (3) step(0, 0, 0, 0, 1, 0, 0);
        chk("fl_none", popped.size(), 0);
        step(1, 32'h000F8073, 3'd5, 32'd31, 1, 0, 0);
        chk("z_imm", imm32, ZEN ? 32'h1F : 32'h0);
        chk("z_ill", ill32, ZEN ? 1'b0 : 1'b1);
        step(1, 32'hFFFFFFFF, 3'd7, 32'd32, 1, 0, 0);
        chk("r7_imm", imm64, 0);
        chk("r7_ill", ill32, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 79) == 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        check_state();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
